// File: rtl/egress_fifo_pkg.sv
// Shared types and helpers for the egress FIFO read side: FSM encoding,
// one-hot to index conversion and round-robin pointer stepping.
package egress_fifo_pkg;

   localparam int NQ = 16;
   localparam int AW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADR   = 2'd1,
      FIRST = 2'd2,
      BURST = 2'd3
   } state_t;

   function automatic logic [AW-1:0] onehot2bin(input logic [NQ-1:0] oh);
      logic [AW-1:0] b;
      b = '0;
      for (int i = 0; i < NQ; i++) begin
         if (oh[i]) b = b | AW'(i);
      end
      return b;
   endfunction

   // Next queue index in cyclic order; queue NQ-1 wraps to queue 0.
   function automatic logic [AW-1:0] rr_next(input logic [AW-1:0] p);
      return (p == AW'(NQ - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/egress_read_scheduler_rr_arbiter.sv
// Combinational round-robin select: first requesting queue found when
// searching cyclically from ptr+1, as a one-hot vector and as an index.
module rr_arbiter
   import egress_fifo_pkg::*;
#(
   parameter int n = 16,
   parameter int a = 4
) (
   input  logic [n-1:0] req,
   input  logic [a-1:0] ptr,
   output logic [n-1:0] grant_oh,
   output logic [a-1:0] grant_idx,
   output logic         any
);

   logic [a-1:0] idx;
   logic         found;

   always_comb begin
      grant_oh = '0;
      found    = 1'b0;
      idx      = rr_next(ptr);
      for (int k = 0; k < n; k++) begin
         if (!found && req[idx]) begin
            grant_oh[idx] = 1'b1;
            found         = 1'b1;
         end
         idx = rr_next(idx);
      end
   end

   assign grant_idx = onehot2bin(grant_oh);
   assign any       = |req;

endmodule

// File: rtl/egress_read_scheduler.sv
// Read-side scheduler for the multi-queue egress FIFO: round-robin grant,
// read_adr/read_data burst sequencing and a q-aligned valid/last/queue tag.
module egress_read_scheduler #(
   parameter int nr_of_queues = 16,
   parameter int a_hi_size    = 4,
   parameter int burst_len    = 4,
   parameter int rd_latency   = 2
) (
   input  logic                   clk2,
   input  logic                   rst2,
   input  logic                   enable,
   input  logic [0:nr_of_queues-1] fifo_empty,
   input  logic                   dst_ready,
   output logic                   read_adr,
   output logic                   read_data,
   output logic [0:nr_of_queues-1] read_enable,
   output logic                   q_valid,
   output logic                   q_last,
   output logic [a_hi_size-1:0]   q_queue,
   output logic                   burst_short,
   output logic                   busy
);
   import egress_fifo_pkg::*;

   localparam logic [3:0] BL = 4'(burst_len);

   typedef struct packed {
      logic                 valid;
      logic                 last;
      logic [a_hi_size-1:0] queue;
   } tag_t;

   state_t                  state;
   logic [a_hi_size-1:0]    ptr;
   logic [3:0]              cnt;
   logic [nr_of_queues-1:0] req;
   logic [nr_of_queues-1:0] gnt_oh;
   logic [a_hi_size-1:0]    gnt_idx;
   logic                    any_req;
   logic                    sel_empty;
   logic                    issue;
   logic                    issue_last;
   tag_t                    pipe [rd_latency];

   always_comb begin
      req = '0;
      for (int i = 0; i < nr_of_queues; i++) req[i] = ~fifo_empty[i];
   end

   rr_arbiter #(.n(nr_of_queues), .a(a_hi_size)) u_arb (
      .req       (req),
      .ptr       (ptr),
      .grant_oh  (gnt_oh),
      .grant_idx (gnt_idx),
      .any       (any_req)
   );

   // After a grant ptr is the granted queue, so it doubles as the grant index.
   assign sel_empty = fifo_empty[ptr];

   // A word is issued in BURST only when the queue has data and dst_ready is
   // high in that same cycle; otherwise the word simply waits (no strobe).
   always_comb begin
      issue      = 1'b0;
      issue_last = 1'b0;
      read_data  = 1'b0;
      case (state)
         FIRST: begin
            issue      = 1'b1;
            issue_last = (BL == 4'd1);
         end
         BURST: begin
            if (!sel_empty && dst_ready && (cnt < BL)) begin
               read_data  = 1'b1;
               issue      = 1'b1;
               issue_last = (cnt + 4'd1 == BL);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk2 or posedge rst2) begin
      if (rst2) begin
         state       <= IDLE;
         ptr         <= a_hi_size'(nr_of_queues - 1);
         cnt         <= '0;
         read_adr    <= 1'b0;
         read_enable <= '0;
         burst_short <= 1'b0;
         busy        <= 1'b0;
      end else begin
         read_adr    <= 1'b0;
         burst_short <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && dst_ready && any_req) begin
                  for (int i = 0; i < nr_of_queues; i++) read_enable[i] <= gnt_oh[i];
                  ptr      <= gnt_idx;
                  read_adr <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ADR;
               end
            end
            // The FIFO is committed by read_adr, so an empty flag here is ignored.
            ADR: state <= FIRST;
            FIRST: begin
               cnt <= 4'd1;
               if (issue_last) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= BURST;
               end
            end
            BURST: begin
               if (issue) begin
                  cnt <= cnt + 4'd1;
                  if (issue_last) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else if (sel_empty) begin
                  burst_short <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk2 or posedge rst2) begin
      if (rst2) begin
         for (int i = 0; i < rd_latency; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {issue, issue & issue_last, issue ? ptr : {a_hi_size{1'b0}}};
         for (int i = 1; i < rd_latency; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q_valid = pipe[rd_latency-1].valid;
   assign q_last  = pipe[rd_latency-1].last;
   assign q_queue = pipe[rd_latency-1].queue;

endmodule

// File: tb/tb_egress_read_scheduler.sv
// Self-checking bench for egress_read_scheduler with a behavioural FIFO
// occupancy model and a tag scoreboard on the q-side outputs.
module tb_egress_read_scheduler;

   logic        clk2 = 1'b0;
   logic        rst2 = 1'b0;
   logic        enable = 1'b0;
   logic        dst_ready = 1'b0;
   logic [0:15] fifo_empty = '1;
   logic        read_adr;
   logic        read_data;
   logic [0:15] read_enable;
   logic        q_valid;
   logic        q_last;
   logic [3:0]  q_queue;
   logic        burst_short;
   logic        busy;

   always #5 clk2 = ~clk2;

   egress_read_scheduler #(
      .nr_of_queues (16),
      .a_hi_size    (4),
      .burst_len    (4),
      .rd_latency   (2)
   ) dut (
      .clk2        (clk2),
      .rst2        (rst2),
      .enable      (enable),
      .fifo_empty  (fifo_empty),
      .dst_ready   (dst_ready),
      .read_adr    (read_adr),
      .read_data   (read_data),
      .read_enable (read_enable),
      .q_valid     (q_valid),
      .q_last      (q_last),
      .q_queue     (q_queue),
      .burst_short (burst_short),
      .busy        (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int         cyc = 0;
   int         avail [16];
   logic       adv = 1'b0;
   int         adv_q = -1;
   logic       adr_prev = 1'b0;
   int         adr_cyc[$];
   int         grant_q[$];
   int         rd_cyc[$];
   int         qv_cyc[$];
   int         short_cnt = 0;
   int         both_total = 0;
   logic [4:0] exp_q[$];
   logic [4:0] sb_e;

   function automatic int oh_idx(input logic [0:15] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk2) cyc++;

   // Monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk2) begin
      if (read_adr) begin
         adr_cyc.push_back(cyc);
         grant_q.push_back(oh_idx(read_enable));
         check("grant_onehot", $countones(read_enable), 1);
      end
      if (read_data) rd_cyc.push_back(cyc);
      if (read_adr && read_data) both_total++;
      if (burst_short) short_cnt++;
      if (q_valid) begin
         qv_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("sb_extra_word", q_valid, 0);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_tag", {q_last, q_queue}, sb_e);
         end
      end
      adv      = read_data || adr_prev;
      adv_q    = oh_idx(read_enable);
      adr_prev = read_adr;
   end

   // FIFO occupancy model: a pointer advance lowers the count, and the empty
   // flags follow just after the edge that completed the advance.
   always @(posedge clk2) begin
      #1;
      if (adv && adv_q >= 0 && avail[adv_q] > 0) avail[adv_q]--;
      adv = 1'b0;
      for (int i = 0; i < 16; i++) fifo_empty[i] = (avail[i] == 0);
   end

   task automatic tick();
      @(posedge clk2);
      #2;
   endtask

   task automatic clear_rec();
      adr_cyc.delete();
      grant_q.delete();
      rd_cyc.delete();
      qv_cyc.delete();
      short_cnt = 0;
   endtask

   task automatic do_reset();
      rst2 = 1'b1;
      repeat (2) tick();
      rst2 = 1'b0;
      tick();
   endtask

   task automatic push_burst(input int q, input int n, input bit full);
      for (int k = 0; k < n; k++) exp_q.push_back({full && (k == n - 1), 4'(q)});
   endtask

   task automatic wait_grants(input int k);
      int n;
      n = 0;
      while (adr_cyc.size() < k && n < 300) begin
         tick();
         n++;
      end
      check("grant_timeout", adr_cyc.size() >= k, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      repeat (4) tick();
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("idle_timeout", n < 200, 1);
      repeat (4) tick();
   endtask

   int t0;
   int busy_seen;
   int n_wait;
   int exp_order [5] = '{0, 5, 15, 0, 5};

   initial begin
      for (int i = 0; i < 16; i++) avail[i] = 0;

      // Reset state
      #1 rst2 = 1'b1;
      #1;
      check("reset_outputs",
            {read_adr, read_data, read_enable, q_valid, q_last, q_queue, burst_short, busy}, 0);
      repeat (3) tick();
      rst2 = 1'b0;
      tick();

      // All queues empty: nothing happens
      enable    = 1'b1;
      dst_ready = 1'b1;
      clear_rec();
      busy_seen = 0;
      repeat (100) begin
         tick();
         if (busy) busy_seen++;
      end
      check("empty_no_adr", adr_cyc.size(), 0);
      check("empty_no_data", rd_cyc.size(), 0);
      check("empty_no_busy", busy_seen, 0);

      // Single full burst from queue 3 with exact timing
      clear_rec();
      avail[3] = 4;
      push_burst(3, 4, 1'b1);
      wait_grants(1);
      wait_idle();
      t0 = adr_cyc[0];
      check("q3_grant", grant_q[0], 3);
      check("q3_rd_count", rd_cyc.size(), 3);
      check("q3_rd_first", rd_cyc[0], t0 + 2);
      check("q3_rd_last", rd_cyc[2], t0 + 4);
      check("q3_qv_count", qv_cyc.size(), 4);
      check("q3_qv_first", qv_cyc[0], t0 + 3);
      check("q3_qv_last", qv_cyc[3], t0 + 6);
      check("q3_sb_drained", exp_q.size(), 0);

      // Round-robin across 0, 5, 15 with wrap
      enable = 1'b0;
      do_reset();
      clear_rec();
      avail[0]  = 100;
      avail[5]  = 100;
      avail[15] = 100;
      for (int b = 0; b < 5; b++) push_burst(exp_order[b], 4, 1'b1);
      enable = 1'b1;
      wait_grants(5);
      enable = 1'b0;
      wait_idle();
      for (int b = 0; b < 5; b++) check("rr_order", grant_q[b], exp_order[b]);
      for (int b = 0; b < 4; b++) check("rr_spacing", adr_cyc[b+1] - adr_cyc[b], 6);
      check("rr_sb_drained", exp_q.size(), 0);
      check("rr_no_short", short_cnt, 0);

      // Queue 7 runs dry after two words
      avail[0]  = 0;
      avail[5]  = 0;
      avail[15] = 0;
      tick();
      clear_rec();
      avail[7] = 2;
      push_burst(7, 2, 1'b0);
      enable = 1'b1;
      wait_grants(1);
      enable = 1'b0;
      wait_idle();
      check("short_rd_count", rd_cyc.size(), 1);
      check("short_pulse", short_cnt, 1);
      check("short_qv_count", qv_cyc.size(), 2);
      check("short_sb_drained", exp_q.size(), 0);

      // dst_ready stall of three cycles mid-burst
      clear_rec();
      avail[2] = 10;
      push_burst(2, 4, 1'b1);
      enable = 1'b1;
      wait_grants(1);
      enable = 1'b0;
      n_wait = 0;
      while (rd_cyc.size() < 1 && n_wait < 50) begin
         tick();
         n_wait++;
      end
      dst_ready = 1'b0;
      repeat (3) tick();
      dst_ready = 1'b1;
      wait_idle();
      check("stall_rd_count", rd_cyc.size(), 3);
      check("stall_gap", rd_cyc[1] - rd_cyc[0], 4);
      check("stall_resume", rd_cyc[2] - rd_cyc[1], 1);
      check("stall_qv_count", qv_cyc.size(), 4);
      check("stall_sb_drained", exp_q.size(), 0);
      check("stall_no_short", short_cnt, 0);

      // Reset during BURST aborts; queue 0 wins first afterwards
      avail[2] = 0;
      tick();
      clear_rec();
      avail[5] = 10;
      enable = 1'b1;
      wait_grants(1);
      enable = 1'b0;
      n_wait = 0;
      while (rd_cyc.size() < 1 && n_wait < 50) begin
         tick();
         n_wait++;
      end
      rst2 = 1'b1;
      #1;
      check("midrst_outputs",
            {read_adr, read_data, read_enable, q_valid, q_last, q_queue, burst_short, busy}, 0);
      avail[5] = 0;
      avail[0] = 4;
      avail[8] = 4;
      repeat (2) tick();
      clear_rec();
      push_burst(0, 4, 1'b1);
      rst2   = 1'b0;
      enable = 1'b1;
      wait_grants(1);
      enable = 1'b0;
      wait_idle();
      check("midrst_first_grant", grant_q[0], 0);
      check("midrst_qv_count", qv_cyc.size(), 4);
      check("midrst_sb_drained", exp_q.size(), 0);

      check("adr_data_overlap", both_total, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/egress_read_scheduler.md
Name: egress_read_scheduler

Overview:
- Read-side controller for the multi-queue egress FIFO in the clk2 domain.
- Watches the per-queue empty flags and picks a non-empty queue by round-robin.
- Drives the FIFO's read_adr / read_data / read_enable sequence for a burst of up to burst_len words.
- Emits a valid/last/queue tag aligned with the FIFO's registered q output, so downstream logic (SDRAM/Wishbone return path) can consume words without extra bookkeeping.

Parameters:
- nr_of_queues, 16, number of FIFO queues (width of empty flags and read_enable).
- a_hi_size, 4, width of the queue index (q_queue); 2**a_hi_size >= nr_of_queues.
- burst_len, 4, maximum words read per grant; legal range 1..15.
- rd_latency, 2, cycles from a pointer-advance cycle until the word is valid on the FIFO q output.

Ports:
- clk2  in  1  read clock.
- rst2  in  1  reset.
- enable  in  1  allows new grants; a burst already in progress always completes.
- fifo_empty  in  [0:nr_of_queues-1]  per-queue empty flags from the FIFO.
- dst_ready  in  1  consumer can accept a word issued this cycle.
- read_adr  out  1  one-cycle strobe that latches read_enable inside the FIFO.
- read_data  out  1  advances the selected queue's read pointer.
- read_enable  out  [0:nr_of_queues-1]  one-hot queue select, sampled with read_adr.
- q_valid  out  1  FIFO q holds a word this cycle.
- q_last  out  1  qualifies q_valid; final word of a full-length burst.
- q_queue  out  [a_hi_size-1:0]  queue index of the word on q.
- burst_short  out  1  one-cycle pulse: burst ended early because the queue went empty.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset: rst2 is asynchronous, active-high; clock is clk2.
  - All outputs reset to 0 and FSM goes to IDLE.
  - Word count and the valid/last/queue pipeline are cleared.
  - Round-robin pointer resets to nr_of_queues-1, so queue 0 has first priority.
  - Reset mid-burst aborts the burst with no further strobes.
- FSM states: IDLE, ADR, FIRST, BURST.
- IDLE:
  - Leaves IDLE when enable=1, dst_ready=1 and any fifo_empty bit is 0.
  - Grant = first non-empty queue searching cyclically from pointer+1.
  - Registers read_enable=onehot(grant) and sets pointer=grant; goes to ADR.
- ADR (1 cycle):
  - read_adr=1, read_data=0, read_enable held.
  - If fifo_empty[grant]=1 in this cycle, still proceeds; the FIFO has already been committed via read_adr.
  - Goes to FIRST.
- FIRST (1 cycle):
  - FIFO performs the first pointer advance internally via its registered read_adr.
  - read_data MUST be 0 here, otherwise the same advance would be counted twice.
  - Counts this as word 1 (cnt=1) and injects an issue event into the pipeline.
  - If burst_len=1, tags this word last and goes to IDLE; otherwise goes to BURST.
- BURST:
  - read_data=1 exactly when fifo_empty[grant]=0 and dst_ready=1 and cnt<burst_len; each such cycle is an issue event and increments cnt.
  - dst_ready=0 with queue not empty: stall, no strobe, stay in BURST.
  - The issue with cnt+1==burst_len is tagged last; FSM goes to IDLE after it.
  - fifo_empty[grant]=1 with cnt<burst_len: pulse burst_short, go to IDLE; no last tag is generated.
- read_enable holds its value until the next grant and never changes outside IDLE->ADR.
- read_adr and read_data are never asserted in the same cycle.
- Output pipeline:
  - Each issue event enters a rd_latency-deep shift register carrying {valid, last, grant index}.
  - Its output drives q_valid/q_last/q_queue, so q_valid is asserted exactly rd_latency cycles after the issue cycle.
  - Total latency from grant in IDLE to the first q_valid is 1 (ADR) + 1 (FIRST) + rd_latency cycles.
- Back-to-back operation: a new grant may be made in the first IDLE cycle after a burst ends, so there is at least one idle cycle between the final read_data and the next read_adr.
- Pointer wrap: a search from nr_of_queues-1 wraps to queue 0.
- Single non-empty queue: the same queue may be re-granted consecutively.

Decomposition:
- Shared package (egress_fifo_pkg): FSM state encoding, a onehot2bin function of width nr_of_queues -> a_hi_size, and a rr_next function.
- One natural sub-module: rr_arbiter (combinational masked round-robin select: request vector plus pointer -> one-hot grant plus index).
- The FSM, word counter and tag pipeline stay in this module.

Test Plan:
- Reset, then fifo_empty all 1 -> no strobes, busy=0 for 100 cycles.
- Queue 3 non-empty, burst_len=4, dst_ready=1 -> read_enable[3]=1, then read_adr at cycle T, read_data at T+2..T+4, q_valid at T+3..T+6 with q_queue=3 and q_last only at T+6.
- Queues 0, 5 and 15 non-empty continuously -> grant order 0, 5, 15, 0, 5 (wrap verified); one idle cycle between bursts.
- Queue 7 goes empty after 2 words -> read_data only once, burst_short pulses, exactly 2 q_valid, no q_last.
- dst_ready low for 3 cycles mid-burst -> read_data gap of 3 cycles, total 4 words delivered, q_last still on the 4th word.
- rst2 asserted during BURST -> all outputs 0 immediately; after release, queue 0 is granted first.
